// File: rtl/stream_vec_source.sv
// stream_vec_source: RAM-backed valid/ready stream source feeding a 2-entry output buffer.
// Define STREAM_SRC_THROTTLE_EN to add an LFSR that inserts pseudo-random valid gaps.
module stream_vec_source #(
  parameter int unsigned T     = 8,
  parameter int unsigned DEPTH = 10000,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [T-1:0]  cfg_data,
  input  logic [AW:0]   cfg_len,
  input  logic          start,
  output logic [T-1:0]  m_data_out_x,
  output logic          m_valid_x,
  input  logic          m_ready_x,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   sent_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [T-1:0] mem [DEPTH];
  logic [T-1:0] ram_q, out_data, pf_data;
  logic [AW:0]  len, rd_ptr;
  logic         out_valid, pf_valid, pend;
  logic         start_ok, fire, gate, load, pend_move, pf_fill, issue;
  logic [1:0]   occ_left;

  assign start_ok     = start && (state != RUN);
  assign m_valid_x    = out_valid;
  assign m_data_out_x = out_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (sent_count == len) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

`ifdef STREAM_SRC_THROTTLE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             lfsr <= SEED;
    else if (state == RUN)  lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign gate = lfsr[0];
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
  assign gate        = 1'b1;
`endif

  // ram_q only reloads on a read, so an unconsumed word may wait there while pf is full.
  always_comb begin
    fire      = out_valid && m_ready_x;
    load      = (!out_valid || fire) && gate && (pf_valid || pend);
    pend_move = pend && (load || !pf_valid);
    pf_fill   = pend && (pf_valid ? load : !load);
    occ_left  = 2'(out_valid) + 2'(pf_valid) + 2'(pend) - 2'(fire);
    issue     = (state == RUN) && (rd_ptr < len) && (occ_left < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (cfg_we && (state != RUN)) mem[cfg_addr] <= cfg_data;
    if (issue)                    ram_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len        <= '0;
      rd_ptr     <= '0;
      sent_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      pf_valid   <= 1'b0;
      pf_data    <= '0;
      pend       <= 1'b0;
    end else if (start_ok) begin
      len        <= (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
      rd_ptr     <= '0;
      sent_count <= '0;
      out_valid  <= 1'b0;
      pf_valid   <= 1'b0;
      pend       <= 1'b0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (fire)  sent_count <= sent_count + (AW+1)'(1);
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pf_valid ? pf_data : ram_q;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      if (!pf_valid || load) begin
        pf_valid <= pf_fill;
        if (pf_fill) pf_data <= ram_q;
      end
      pend <= issue || (pend && !pend_move);
    end
  end
endmodule

// File: doc/stream_vec_source.md
# stream_vec_source

Memory-backed stream transmitter that drives the `s_data_in_x` / `s_valid_x` / `s_ready_x` input port of the `multi_*` network layers. It replaces the bench-side input driver with synthesizable RTL for on-board self-test and for hardware-in-loop runs. Software preloads a vector into internal RAM, pulses `start`, and the block streams exactly `cfg_len` words under a valid/ready handshake. An optional LFSR throttle inserts pseudo-random valid gaps.

## Interface
- `T`, 8, data word width (matches the consuming layer's `T`)
- `DEPTH`, 10000, vector RAM depth in words; `AW = $clog2(DEPTH)`
- `SEED`, 16'hACE1, LFSR seed; must be nonzero (used only with throttle compiled in)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  RAM write strobe; honoured only in IDLE or DONE
- `cfg_addr`  in  AW  RAM write address
- `cfg_data`  in  T  RAM write data
- `cfg_len`  in  AW+1  number of words to send; sampled on `start`
- `start`  in  1  one-cycle pulse; honoured only in IDLE or DONE
- `m_data_out_x`  out  T  stream data (connects to the layer's `s_data_in_x`)
- `m_valid_x`  out  1  stream valid
- `m_ready_x`  in  1  stream ready (from the layer's `s_ready_x`)
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE, until the next `start`
- `sent_count`  out  AW+1  handshakes completed in the current or last run

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the cycle after the handshake that makes `sent_count == len`.
  - DONE → RUN on `start`.
- On `start`:
  - latch `len = min(cfg_len, DEPTH)`;
  - clear the read pointer and `sent_count`;
  - flush the buffer.
- `len == 0`: RUN → DONE on the next cycle. `m_valid_x` never asserts.
- RAM read is synchronous, with 1-cycle address-to-data latency.
- A 2-entry buffer (output register plus prefetch register) sustains one beat per cycle.
- The read pointer never advances past `len`, so no extra reads are issued.
- A beat is transferred when `m_valid_x && m_ready_x` on a rising edge; `sent_count` increments on that edge.
- Words are sent in address order 0 … `len-1`. There is no wrap-around.
- Handshake rules:
  - Once `m_valid_x` is high, it stays high and `m_data_out_x` stays stable until the handshake.
  - `m_valid_x` never depends combinationally on `m_ready_x`.
- `m_data_out_x` holds its last value when `m_valid_x` is low.
- `cfg_we` in RUN is ignored; RAM contents are unchanged.
- `start` in RUN is ignored.

## Timing
- Reset (asserted low) forces, immediately and asynchronously:
  - state = IDLE;
  - `m_valid_x`, `busy`, `done` = 0;
  - `sent_count` = 0;
  - `m_data_out_x` = 0;
  - buffer emptied.
- RAM contents are not reset.
- `start` sampled at edge N: `busy` is high after edge N, and the first `m_valid_x` is high after edge N+2 (unthrottled).
- With `m_ready_x` held high and no throttle, `len` beats occupy `len` consecutive cycles.
- Last handshake at edge M: `done` is high and `busy` is low after edge M+1.
- Reset deasserted mid-RUN, then `start`: the run replays from address 0 with `sent_count` restarting at 0.

## Configuration
- `STREAM_SRC_THROTTLE_EN`
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is loaded with `SEED` on reset and advances every clock in RUN. A new beat may be presented only in a cycle where LFSR bit0 == 1. A beat already presented is held regardless of the LFSR.
  - Undefined: no LFSR logic. `m_valid_x` asserts whenever the buffer holds a word.

## Test plan
- Load 0x11, 0x22, 0x33, 0x44; `cfg_len = 4`; `m_ready_x = 1`; `start` at edge N → beats 0x11..0x44 on edges N+3..N+6; `done = 1`, `sent_count = 4` after edge N+7.
- Load 256 words = index; `cfg_len = 256`; `m_ready_x` random at 50% → 256 beats in order, no drops or duplicates, data stable whenever `m_valid_x && !m_ready_x`.
- `cfg_len = 0` → `done` after edge N+1; `m_valid_x` stays 0.
- `cfg_len = 20000` with `DEPTH = 10000` → exactly 10000 beats, then `done`.
- Pull `reset` low after 2 handshakes → outputs clear without waiting for a clock edge; a new `start` resends from word 0.
- `STREAM_SRC_THROTTLE_EN` defined, `SEED = 16'hACE1`, `m_ready_x = 1` → valid pattern matches the reference LFSR bit0 model. `cfg_we` to address 0 during RUN leaves word 0 unchanged on the next run.
